// File: rtl/mem_pkg.sv
// Shared memory-side definitions for the arbiter and memory controller.
// Opcode encoding seen on req_op and mc_op.
package mem_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b11
  } mem_op_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first eligible requester after i_last,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_win,
  output logic          o_valid
);

  int          w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = int'(i_last) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = IW'(w_sum);
      if (!o_valid && i_elig[w_idx]) begin
        o_win[w_idx] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting N requesters exclusive use of a
// single memory controller, with a per-transaction watchdog.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int WORD_SIZE     = 32,
  parameter int ADDR_BITCOUNT = 64,
  parameter int TIMEOUT       = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [2*NUM_REQ-1:0]             req_op,
  input  logic [ADDR_BITCOUNT*NUM_REQ-1:0] req_addr,
  input  logic [WORD_SIZE*NUM_REQ-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [NUM_REQ-1:0]               req_rd_valid,
  output logic [WORD_SIZE-1:0]             rdata,
  output logic                             err_timeout,
  input  logic                             mc_ready,
  input  logic                             mc_tx_done,
  input  logic                             mc_rd_valid,
  input  logic [WORD_SIZE-1:0]             mc_rdata,
  output logic [1:0]                       mc_op,
  output logic [ADDR_BITCOUNT-1:0]         mc_addr,
  output logic [WORD_SIZE-1:0]             mc_wdata
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_BUSY,
    S_REL
  } state_e;

  state_e                   r_state;
  state_e                   w_next;
  logic [NUM_REQ-1:0]       r_grant;
  logic [IW-1:0]            r_last;
  mem_op_e                  r_op;
  logic [ADDR_BITCOUNT-1:0] r_addr;
  logic [CW-1:0]            r_wd;

  logic [NUM_REQ-1:0]       w_elig;
  logic [NUM_REQ-1:0]       w_win;
  logic                     w_win_vld;
  logic [IW-1:0]            w_win_idx;
  logic [1:0]               w_sel_op;
  logic [ADDR_BITCOUNT-1:0] w_sel_addr;
  logic [WORD_SIZE-1:0]     w_own_wdata;
  logic                     w_busy;
  logic                     w_expire;
  logic                     w_finish;
  logic                     w_start;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid[i] &&
        (req_op[2*i +: 2] == OP_READ ||
         req_op[2*i +: 2] == OP_WRITE);
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_win   (w_win),
    .o_valid (w_win_vld)
  );

  always_comb begin
    w_win_idx   = '0;
    w_sel_op    = '0;
    w_sel_addr  = '0;
    w_own_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) begin
        w_win_idx  = IW'(i);
        w_sel_op   = req_op[2*i +: 2];
        w_sel_addr = req_addr[i*ADDR_BITCOUNT +: ADDR_BITCOUNT];
      end
      if (r_grant[i])
        w_own_wdata = req_wdata[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  assign w_busy   = (r_state == S_BUSY);
  assign w_expire = w_busy && (r_wd == CW'(TIMEOUT - 1));
  assign w_finish = w_busy && (mc_tx_done || w_expire);
  assign w_start  = (r_state == S_IDLE) && (w_next == S_BUSY);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT: if (mc_ready) w_next = S_IDLE;
      S_IDLE: begin
        if (!mc_ready)      w_next = S_INIT;
        else if (w_win_vld) w_next = S_BUSY;
      end
      S_BUSY: if (w_finish) w_next = S_REL;
      S_REL:  w_next = mc_ready ? S_IDLE : S_INIT;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_grant <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_op    <= OP_IDLE;
      r_addr  <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_grant <= w_win;
        r_last  <= w_win_idx;
        r_op    <= mem_op_e'(w_sel_op);
        r_addr  <= w_sel_addr;
        r_wd    <= '0;
      end else if (w_busy) begin
        if (w_finish) r_grant <= '0;
        if (r_wd != '1) r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign req_grant    = r_grant;
  assign req_done     = w_finish ? r_grant : '0;
  assign req_rd_valid =
    (w_busy && mc_rd_valid) ? r_grant : '0;
  assign rdata        = mc_rdata;
  // Completion beats the watchdog in the same cycle.
  assign err_timeout  = w_expire && !mc_tx_done;
  assign mc_op        = w_busy ? r_op : OP_IDLE;
  assign mc_addr      = w_busy ? r_addr : '0;
  assign mc_wdata     = w_busy ? w_own_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; a second instance with a short
// watchdog exercises the timeout paths.
module tb_mem_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int A = 64;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [A*N-1:0] req_addr;
  logic [W*N-1:0] req_wdata;
  logic           mc_ready;
  logic           mc_tx_done;
  logic           mc_rd_valid;
  logic [W-1:0]   mc_rdata;

  logic [N-1:0] grant, done, rdv;
  logic [W-1:0] rdata;
  logic         err;
  logic [1:0]   mcop;
  logic [A-1:0] mcaddr;
  logic [W-1:0] mcwdata;

  logic [N-1:0] b_grant, b_done, b_rdv;
  logic [W-1:0] b_rdata;
  logic         b_err;
  logic [1:0]   b_mcop;
  logic [A-1:0] b_mcaddr;
  logic [W-1:0] b_mcwdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .NUM_REQ(N), .WORD_SIZE(W), .ADDR_BITCOUNT(A)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(grant), .req_done(done),
    .req_rd_valid(rdv), .rdata(rdata),
    .err_timeout(err), .mc_ready(mc_ready),
    .mc_tx_done(mc_tx_done), .mc_rd_valid(mc_rd_valid),
    .mc_rdata(mc_rdata), .mc_op(mcop),
    .mc_addr(mcaddr), .mc_wdata(mcwdata)
  );

  mem_arbiter #(
    .NUM_REQ(N), .WORD_SIZE(W), .ADDR_BITCOUNT(A),
    .TIMEOUT(8)
  ) u_wd (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(b_grant), .req_done(b_done),
    .req_rd_valid(b_rdv), .rdata(b_rdata),
    .err_timeout(b_err), .mc_ready(mc_ready),
    .mc_tx_done(mc_tx_done), .mc_rd_valid(mc_rd_valid),
    .mc_rdata(mc_rdata), .mc_op(b_mcop),
    .mc_addr(b_mcaddr), .mc_wdata(b_mcwdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n       = 1'b0;
    mc_tx_done  = 1'b0;
    mc_rd_valid = 1'b0;
    #2;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant;
    int n;
    n = 0;
    while (grant == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_wait", 64'(grant != '0), 1);
  endtask

  task automatic serve(input int idx,
                       input logic [1:0] op,
                       input logic [63:0] addr,
                       input int n,
                       input bit drop);
    logic [N-1:0] g;
    bit wr;
    g  = N'(1) << idx;
    wr = (op == 2'b11);
    wait_grant();
    chk("grant_owner", 64'(grant), 64'(g));
    for (int k = 0; k < n; k++) begin
      mc_rd_valid = !wr;
      mc_rdata    = 32'hA000 + k;
      if (wr) req_wdata[idx*W +: W] = 32'(k);
      if (drop && k == n / 2) req_valid[idx] = 1'b0;
      mc_tx_done  = (k == n - 1);
      #1;
      chk("busy_op", 64'(mcop), 64'(op));
      chk("busy_addr", mcaddr, addr);
      if (wr)
        chk("busy_wdata", 64'(mcwdata), 64'(k));
      else begin
        chk("busy_rdv", 64'(rdv), 64'(g));
        chk("busy_rdata", 64'(rdata), 64'(32'hA000 + k));
      end
      chk("busy_done", 64'(done),
          (k == n - 1) ? 64'(g) : 64'd0);
      tick();
    end
    mc_rd_valid = 1'b0;
    mc_tx_done  = 1'b0;
    #1;
    chk("rel_grant", 64'(grant), 0);
    chk("rel_op", 64'(mcop), 0);
    chk("rel_addr", mcaddr, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    mc_ready    = 1'b0;
    mc_tx_done  = 1'b0;
    mc_rd_valid = 1'b0;
    mc_rdata    = '0;
    req_wdata   = '0;
    req_addr    = '0;
    req_valid   = 4'b0001;
    req_op      = 8'b00_00_00_01;
    req_addr[0 +: A] = 64'h1000;
    #3;
    chk("rst_grant", 64'(grant), 0);
    chk("rst_op", 64'(mcop), 0);
    chk("rst_addr", mcaddr, 0);
    chk("rst_wdata", 64'(mcwdata), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("init_nogrant", 64'(grant), 0);
    end
    mc_ready = 1'b1;
    tick();
    chk("idle_nogrant", 64'(grant), 0);
    tick();
    chk("first_grant", 64'(grant), 1);
    chk("first_op", 64'(mcop), 1);
    chk("first_addr", mcaddr, 64'h1000);
    mc_tx_done = 1'b1;
    #1;
    chk("first_done", 64'(done), 1);
    tick();
    mc_tx_done = 1'b0;
    req_valid  = '0;
    #1;
    chk("first_rel", 64'(grant), 0);

    req_valid = 4'b1111;
    req_op    = 8'b01_01_01_01;
    for (int i = 0; i < N; i++)
      req_addr[i*A +: A] = 64'(32'h100 * i);
    do_reset();
    serve(0, 2'b01, 64'h000, 16, 1'b0);
    serve(1, 2'b01, 64'h100, 16, 1'b0);
    serve(2, 2'b01, 64'h200, 16, 1'b0);
    serve(3, 2'b01, 64'h300, 16, 1'b0);
    serve(0, 2'b01, 64'h000, 16, 1'b0);

    req_valid = 4'b0100;
    req_op    = 8'b11_11_00_00;
    req_addr[2*A +: A] = 64'h40;
    tick();
    serve(2, 2'b11, 64'h40, 16, 1'b1);

    req_valid = 4'b0011;
    req_op    = 8'b00_00_01_01;
    do_reset();
    begin
      int n;
      n = 0;
      while (b_grant == '0 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("wd_grant0", 64'(b_grant), 1);
    for (int k = 1; k <= 8; k++) begin
      chk("wd_err", 64'(b_err), 64'(k == 8));
      chk("wd_done", 64'(b_done), (k == 8) ? 1 : 0);
      tick();
    end
    chk("wd_rel", 64'(b_grant), 0);
    chk("wd_rel_op", 64'(b_mcop), 0);
    tick();
    tick();
    chk("wd_grant1", 64'(b_grant), 2);
    for (int k = 1; k <= 8; k++) begin
      mc_tx_done = (k == 8);
      #1;
      chk("wd_tie_err", 64'(b_err), 0);
      chk("wd_tie_done", 64'(b_done), (k == 8) ? 2 : 0);
      tick();
    end
    mc_tx_done = 1'b0;

    req_valid = 4'b0011;
    req_op    = 8'b00_00_01_10;
    req_addr[1*A +: A] = 64'h200;
    do_reset();
    serve(1, 2'b01, 64'h200, 2, 1'b0);
    req_valid = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("badop_nogrant", 64'(grant), 0);
    end

    req_valid = 4'b1111;
    req_op    = 8'b01_01_01_01;
    req_addr[0 +: A] = 64'h000;
    do_reset();
    serve(0, 2'b01, 64'h000, 2, 1'b0);
    wait_grant();
    chk("mid_grant", 64'(grant), 2);
    #2;
    mc_tx_done = 1'b1;
    rst_n      = 1'b0;
    #1;
    chk("async_grant", 64'(grant), 0);
    chk("async_op", 64'(mcop), 0);
    chk("async_done", 64'(done), 0);
    mc_tx_done = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_grant();
    chk("post_rst_grant", 64'(grant), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
